stepper_axis_ctrl: RTL
======================

Name: stepper_axis_ctrl

Overview:
- One instance per axis (x/y/z); sequences a step/dir stepper driver from HPS-written PIO registers.
- Registers driving each instance: target, min/max speed, accel step, home speed/location, upper/lower limits, ctrl.
- Generates a trapezoidal step-period profile, tracks absolute location, runs homing against a home switch.
- Reports location and status back through input PIOs.

Parameters:
- PULSE_W, 100, step pulse high time in clk cycles.
- DIR_SETUP, 50, cycles between a dir change and the first step.
- MIN_PERIOD, 200, hard floor on step period; must be >= 2*PULSE_W.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ctrl  in  32  bit0 enable, bit1 go, bit2 home, bit3 stop, bit4 clr_fault; bits 1, 2, 4 are rising-edge-detected
- target  in  32  signed absolute target position, in steps
- max_speed  in  32  cruise step period, clk cycles (smaller = faster)
- min_speed  in  32  start/stop step period, clk cycles
- accel_step  in  32  period change per step while ramping
- home_speed  in  32  constant step period during homing
- home_loc  in  32  signed value loaded into location at the home switch
- upper_limit  in  32  signed soft limit, inclusive
- lower_limit  in  32  signed soft limit, inclusive
- home_sw  in  1  asynchronous home switch, active-high
- step  out  1  step pulse to driver
- dir  out  1  1 = positive direction
- drv_en  out  1  driver enable
- location  out  32  signed current position
- status  out  32  bit0 busy, bit1 at_target, bit2 homed, bit3 limit_err, [6:4] state code, rest 0

Behaviour:
- Reset values: step=0, dir=0, drv_en=0, location=0, status=0, state IDLE; internal period/ramp counters 0.
- home_sw passes through a 2-FF synchronizer; edges of ctrl bits 1, 2, 4 are detected against a registered copy.
- drv_en = ctrl[0], registered, 1-cycle latency.
- Gating: with enable low, go/home edges are ignored; dropping enable mid-move forces IDLE on the next cycle with no deceleration.
- Effective period: eff(p) = max(p, MIN_PERIOD). Applies to max_speed, min_speed, home_speed.
- State codes: IDLE=0, SETUP=1, ACCEL=2, CRUISE=3, DECEL=4, HOME=5, FAULT=6.
- IDLE, go edge, target==location: no motion; at_target=1.
- IDLE, go edge, target outside [lower_limit, upper_limit]: enter FAULT; limit_err=1; no steps.
- IDLE, go edge, otherwise: latch target; dir = (target > location); cur_period = eff(min_speed); ramp_cnt = 0; enter SETUP.
- SETUP: wait DIR_SETUP cycles, then enter ACCEL.
- Step timing (ACCEL/CRUISE/DECEL/HOME):
  - A down-counter loads cur_period; step is high for the first PULSE_W cycles of each period.
  - location updates ±1 on the cycle step rises.
- ACCEL, per step:
  - cur_period = max(cur_period − accel_step, eff(max_speed)), saturating with no underflow.
  - ramp_cnt += 1.
  - When cur_period reaches eff(max_speed), enter CRUISE.
- Decel trigger, checked in ACCEL and CRUISE at each step: remaining = |latched_target − location| after the update; if remaining <= ramp_cnt, enter DECEL.
- DECEL, per step:
  - cur_period = min(cur_period + accel_step, eff(min_speed)).
  - ramp_cnt −= 1, saturating at 0.
- Move completion: when location == latched_target, enter IDLE at the end of the current pulse; at_target=1.
- Short moves: a triangular profile (target reached before cruise) is handled by the same decel trigger.
- Stop level (bit3) in ACCEL/CRUISE: enter DECEL; when ramp_cnt==0, enter IDLE at the end of the current pulse; at_target=0.
- Stop level in HOME: enter IDLE immediately.
- HOME entry, from IDLE on a home edge: dir=0; enter SETUP, then HOME; constant period eff(home_speed).
- Synchronized home_sw high in HOME (including before the first step): location = home_loc; homed=1; enter IDLE; no further steps are issued.
- Soft limits are not checked in HOME.
- Clearing homed: homed is cleared by reset only.
- Priority within a cycle: enable low > stop > home_sw > step/ramp update; go/home edges are ignored while busy.
- FAULT: step held 0; clr_fault edge clears limit_err and returns to IDLE.
- Flags: busy = state ∉ {IDLE, FAULT}. at_target is cleared on leaving IDLE.
- Reset mid-operation: asynchronous return to reset values; homed lost.

Decomposition:
- Package stepper_pkg: state enum, ctrl bit indices (CTRL_EN, CTRL_GO, CTRL_HOME, CTRL_STOP, CTRL_CLR), status bit/field positions.
- Sub-module step_pulse_gen: period down-counter plus PULSE_W pulse shaper; inputs period and run, output step and step_tick.
- Top-level FSM and profile arithmetic stay in stepper_axis_ctrl.

Test Plan:
- Basic move:
  - Setup: enable=1, location=0, target=10, min_speed=1000, max_speed=400, accel_step=200, limits ±1000.
  - Stimulus: go.
  - Response: exactly 10 step pulses, dir=1, periods 1000,800,600,400,400,400,400,600,800,1000 (±1 cycle); location=10, at_target=1, busy=0.
- Triangular short move:
  - Setup: target=−3 from 0, same speeds.
  - Response: 3 steps, dir=0, periods 1000,800,1000; location=−3.
- Limit fault:
  - Setup: target=2000, upper_limit=1000.
  - Stimulus: go.
  - Response: no step; state=FAULT, limit_err=1; clr_fault → IDLE, limit_err=0.
- Homing:
  - Setup: home_speed=500, home_loc=−5, home_sw raised after 7 steps.
  - Stimulus: home edge.
  - Response: dir=0, steps every 500 cycles, stepping stops within 3 cycles of home_sw; location=−5, homed=1.
- Stop mid-cruise:
  - Setup: target=100.
  - Stimulus: assert stop at step 20.
  - Response: ramp of 3 decelerating steps (400→600→800→1000 periods), then IDLE, location=23, at_target=0.
- Reset/enable abort:
  - Stimulus: drop enable mid-move.
  - Response: IDLE next cycle, step=0.
  - Stimulus: assert reset mid-move.
  - Response: location=0, status=0, step=0 asynchronously.

Source files
------------

// File: rtl/stepper_pkg.sv
// Shared types and field positions for the stepper axis controller.
// Pure definitions: no logic, no latency, no flow control.
package stepper_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCEL  = 3'd2,
        ST_CRUISE = 3'd3,
        ST_DECEL  = 3'd4,
        ST_HOME   = 3'd5,
        ST_FAULT  = 3'd6
    } state_t;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_GO   = 1;
    localparam int CTRL_HOME = 2;
    localparam int CTRL_STOP = 3;
    localparam int CTRL_CLR  = 4;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_AT_TGT   = 1;
    localparam int STAT_HOMED    = 2;
    localparam int STAT_LIM_ERR  = 3;
    localparam int STAT_CODE_LSB = 4;
    localparam int STAT_CODE_MSB = 6;

    function automatic logic [31:0] eff_period(input logic [31:0] p, input logic [31:0] floor_p);
        return (p < floor_p) ? floor_p : p;
    endfunction

endpackage

// File: rtl/step_pulse_gen.sv
// Period down-counter and pulse shaper: step rises one cycle after step_tick, stays high PULSE_W cycles.
// No backpressure; deasserting run clears the counter and drops step on the next edge.
module step_pulse_gen #(
    parameter int PULSE_W = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] period,
    input  logic        run,
    output logic        step,
    output logic        step_tick,
    output logic        pulse_end
);

    localparam int HW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

    logic [31:0]   cnt;
    logic [HW-1:0] hcnt;

    assign step_tick = run && (cnt == 32'd0);
    assign pulse_end = step && (hcnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= 32'd0;
            hcnt <= '0;
            step <= 1'b0;
        end else if (!run) begin
            cnt  <= 32'd0;
            hcnt <= '0;
            step <= 1'b0;
        end else if (step_tick) begin
            cnt  <= period - 32'd1;
            hcnt <= HW'(PULSE_W - 1);
            step <= 1'b1;
        end else begin
            cnt <= cnt - 32'd1;
            if (hcnt != '0) hcnt <= hcnt - HW'(1);
            else            step <= 1'b0;
        end
    end

endmodule

// File: rtl/stepper_axis_ctrl.sv
// One-axis step/dir sequencer: trapezoidal ramp, soft limits, homing; drv_en and status lag ctrl by one cycle.
// No backpressure: register writes take effect immediately, go/home edges are dropped while busy.
module stepper_axis_ctrl
    import stepper_pkg::*;
#(
    parameter int PULSE_W    = 100,
    parameter int DIR_SETUP  = 50,
    parameter int MIN_PERIOD = 200
) (
    input  logic               clk,
    input  logic               reset,
    input  logic        [31:0] ctrl,
    input  logic signed [31:0] target,
    input  logic        [31:0] max_speed,
    input  logic        [31:0] min_speed,
    input  logic        [31:0] accel_step,
    input  logic        [31:0] home_speed,
    input  logic signed [31:0] home_loc,
    input  logic signed [31:0] upper_limit,
    input  logic signed [31:0] lower_limit,
    input  logic               home_sw,
    output logic               step,
    output logic               dir,
    output logic               drv_en,
    output logic signed [31:0] location,
    output logic        [31:0] status
);

    localparam int          SW   = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;
    localparam logic [31:0] MINP = 32'(MIN_PERIOD);

    state_t state, state_nxt;

    logic               go_q, home_q, clr_q;
    logic [1:0]         hs_q;
    logic               en, go_edge, home_edge, clr_edge, stop, hs;
    logic signed [31:0] tgt, loc_step, diff;
    logic [31:0]        cur_period, ramp_cnt, rem, sub_sat, accel_nxt, dec_nxt, period_sel;
    logic [31:0]        emin, emax, ehome;
    logic [32:0]        dec_sum;
    logic [SW-1:0]      setup_cnt;
    logic               homing, stopping, at_target, homed, limit_err;
    logic               busy, run, tick, pulse_end, trig, done_cond, out_of_lim;
    logic               unused_ctrl;

    assign unused_ctrl = ^ctrl[31:5];
    assign en        = ctrl[CTRL_EN];
    assign stop      = ctrl[CTRL_STOP];
    assign go_edge   = ctrl[CTRL_GO]   & ~go_q;
    assign home_edge = ctrl[CTRL_HOME] & ~home_q;
    assign clr_edge  = ctrl[CTRL_CLR]  & ~clr_q;
    assign hs        = hs_q[1];

    assign emin  = eff_period(min_speed, MINP);
    assign emax  = eff_period(max_speed, MINP);
    assign ehome = eff_period(home_speed, MINP);

    // Remaining distance is measured after the position update of this step.
    assign loc_step = dir ? location + 32'sd1 : location - 32'sd1;
    assign diff     = tgt - loc_step;
    assign rem      = diff[31] ? $unsigned(-diff) : $unsigned(diff);
    assign trig     = (rem <= ramp_cnt);

    assign sub_sat   = (cur_period > accel_step) ? cur_period - accel_step : 32'd0;
    assign accel_nxt = (sub_sat < emax) ? emax : sub_sat;
    assign dec_sum   = {1'b0, cur_period} + {1'b0, accel_step};
    assign dec_nxt   = (dec_sum > {1'b0, emin}) ? emin : dec_sum[31:0];

    assign done_cond  = (location == tgt) || (stopping && ramp_cnt == 32'd0);
    assign out_of_lim = (target > upper_limit) || (target < lower_limit);

    step_pulse_gen #(.PULSE_W(PULSE_W)) u_pulse (
        .clk       (clk),
        .reset     (reset),
        .period    (period_sel),
        .run       (run),
        .step      (step),
        .step_tick (tick),
        .pulse_end (pulse_end)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (busy && !en) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en && go_edge) begin
                        if (target == location) state_nxt = ST_IDLE;
                        else if (out_of_lim)    state_nxt = ST_FAULT;
                        else                    state_nxt = ST_SETUP;
                    end else if (en && home_edge) begin
                        state_nxt = ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (stop)                 state_nxt = ST_IDLE;
                    else if (setup_cnt == '0) state_nxt = homing ? ST_HOME : ST_ACCEL;
                end
                ST_ACCEL: begin
                    if (stop) state_nxt = ST_DECEL;
                    else if (tick) begin
                        if (trig)                   state_nxt = ST_DECEL;
                        else if (accel_nxt == emax) state_nxt = ST_CRUISE;
                    end
                end
                ST_CRUISE: begin
                    if (stop || (tick && trig)) state_nxt = ST_DECEL;
                end
                // Leave only once the pulse in flight has finished.
                ST_DECEL: begin
                    if (done_cond && (pulse_end || (!step && !tick))) state_nxt = ST_IDLE;
                end
                ST_HOME: begin
                    if (stop || hs) state_nxt = ST_IDLE;
                end
                ST_FAULT: begin
                    if (clr_edge) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state != ST_IDLE) && (state != ST_FAULT);
        run  = ((state == ST_ACCEL) || (state == ST_CRUISE) || (state == ST_DECEL) || (state == ST_HOME))
               && en && !((state == ST_HOME) && (stop || hs));
        case (state)
            ST_HOME:  period_sel = ehome;
            ST_DECEL: period_sel = dec_nxt;
            default:  period_sel = cur_period;
        endcase
        status = 32'd0;
        status[STAT_BUSY]    = busy;
        status[STAT_AT_TGT]  = at_target;
        status[STAT_HOMED]   = homed;
        status[STAT_LIM_ERR] = limit_err;
        status[STAT_CODE_MSB:STAT_CODE_LSB] = state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            go_q       <= 1'b0;
            home_q     <= 1'b0;
            clr_q      <= 1'b0;
            hs_q       <= 2'b00;
            drv_en     <= 1'b0;
            dir        <= 1'b0;
            location   <= 32'sd0;
            tgt        <= 32'sd0;
            cur_period <= 32'd0;
            ramp_cnt   <= 32'd0;
            setup_cnt  <= '0;
            homing     <= 1'b0;
            stopping   <= 1'b0;
            at_target  <= 1'b0;
            homed      <= 1'b0;
            limit_err  <= 1'b0;
        end else begin
            go_q   <= ctrl[CTRL_GO];
            home_q <= ctrl[CTRL_HOME];
            clr_q  <= ctrl[CTRL_CLR];
            hs_q   <= {hs_q[0], home_sw};
            drv_en <= en;
            if (tick) location <= loc_step;
            case (state)
                ST_IDLE: begin
                    if (en && go_edge) begin
                        if (target == location) begin
                            at_target <= 1'b1;
                        end else if (out_of_lim) begin
                            limit_err <= 1'b1;
                            at_target <= 1'b0;
                        end else begin
                            tgt        <= target;
                            dir        <= (target > location);
                            cur_period <= emin;
                            ramp_cnt   <= 32'd0;
                            setup_cnt  <= SW'(DIR_SETUP - 1);
                            homing     <= 1'b0;
                            stopping   <= 1'b0;
                            at_target  <= 1'b0;
                        end
                    end else if (en && home_edge) begin
                        dir       <= 1'b0;
                        setup_cnt <= SW'(DIR_SETUP - 1);
                        homing    <= 1'b1;
                        stopping  <= 1'b0;
                        at_target <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (setup_cnt != '0) setup_cnt <= setup_cnt - SW'(1);
                end
                // The step that trips the decel trigger keeps the current period.
                ST_ACCEL: begin
                    if (stop) stopping <= 1'b1;
                    else if (tick && !trig) begin
                        cur_period <= accel_nxt;
                        ramp_cnt   <= ramp_cnt + 32'd1;
                    end
                end
                ST_CRUISE: begin
                    if (stop) stopping <= 1'b1;
                end
                ST_DECEL: begin
                    if (tick) begin
                        cur_period <= dec_nxt;
                        if (ramp_cnt != 32'd0) ramp_cnt <= ramp_cnt - 32'd1;
                    end
                    if (state_nxt == ST_IDLE) at_target <= (location == tgt);
                end
                ST_HOME: begin
                    if (en && !stop && hs) begin
                        location <= home_loc;
                        homed    <= 1'b1;
                    end
                end
                ST_FAULT: begin
                    if (clr_edge) limit_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
